// File: rtl/fifo_pkg.sv
// Types and helpers shared by the synchronous FIFO and its read-side adapter.
package fifo_pkg;

  localparam int BEAT_CNT_W = 32;

  typedef logic [BEAT_CNT_W-1:0] beat_cnt_t;

  function automatic int ptr_w(int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// Small circular skid buffer: absorbs FIFO words already in flight while the
// downstream stream is stalled, presenting the oldest word as head_data.
module fifo_rd_skid
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int BUF_DEPTH  = 2,
  localparam int PW = ptr_w(BUF_DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [PW:0]           occupancy
);

  localparam logic [PW:0] DEPTH_V = (PW+1)'(BUF_DEPTH);

  logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      occupancy <= occupancy + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

  // Storage carries no reset; the occupancy gate below hides stale entries.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head_data = (occupancy != '0) ? mem[rd_ptr] : '0;

  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(occupancy == DEPTH_V && push && !pop));
  a_occ_bound: assert property (@(posedge clk_i) disable iff (rst_i)
    occupancy <= DEPTH_V);

endmodule

// File: rtl/fifo_rd_adapter.sv
// Turns a synchronous FIFO's read port into a valid/ready stream at one word per cycle.
// Optional beat counter output enabled by defining FIFO_RD_ADAPTER_BEAT_CNT_EN.
module fifo_rd_adapter
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int BUF_DEPTH  = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  fifo_empty_i,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data_i,
  output logic                  fifo_rd_en_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
`ifdef FIFO_RD_ADAPTER_BEAT_CNT_EN
  output beat_cnt_t             beat_cnt_o,
`endif
  output logic [DATA_WIDTH-1:0] m_data_o
);

  localparam int PW = ptr_w(BUF_DEPTH);
  localparam int CW = PW + 2;
  localparam logic signed [CW-1:0] DEPTH_S = CW'(BUF_DEPTH);

  logic                  pop;
  logic                  inflight_vld_p1;
  logic [PW:0]           occupancy;
  logic [DATA_WIDTH-1:0] head_data;
  logic signed [CW-1:0]  credit;

  assign m_valid_o = (occupancy != '0);
  assign pop       = m_valid_o & m_ready_i;
  assign m_data_o  = head_data;

  // Slots still free once this cycle's pop leaves; may go to -1 transiently.
  assign credit = DEPTH_S - $signed({1'b0, occupancy})
                - $signed(CW'(inflight_vld_p1)) + $signed(CW'(pop));

  assign fifo_rd_en_o = !rst_i & !fifo_empty_i & !credit[CW-1] & (credit != '0);

  // p0 -> p1: read issued; FIFO data arrives with inflight_vld_p1
  always_ff @(posedge clk_i) begin
    if (rst_i) inflight_vld_p1 <= 1'b0;
    else       inflight_vld_p1 <= fifo_rd_en_o;
  end

  fifo_rd_skid #(
    .DATA_WIDTH (DATA_WIDTH),
    .BUF_DEPTH  (BUF_DEPTH)
  ) u_skid (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push      (inflight_vld_p1),
    .push_data (fifo_rd_data_i),
    .pop       (pop),
    .head_data (head_data),
    .occupancy (occupancy)
  );

`ifdef FIFO_RD_ADAPTER_BEAT_CNT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i)    beat_cnt_o <= '0;
    else if (pop) beat_cnt_o <= beat_cnt_o + 1'b1;
  end
`endif

endmodule
